// File: rtl/seq_detector_param.sv
// Serial pattern detector: PATTERN_LEN-bit pattern on X, registered one-cycle match pulse Y.
// Define SEQDET_COUNT_EN to add a saturating hit counter (count_clr / count ports).
module seq_detector_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1111,
    parameter int                     COUNT_W     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 X,
    input  logic                                 en,
    input  logic                                 overlap,
`ifdef SEQDET_COUNT_EN
    input  logic                                 count_clr,
    output logic [COUNT_W-1:0]                   count,
`endif
    output logic                                 Y,
    output logic [$clog2(PATTERN_LEN+1)-1:0]     fill
);

    localparam int FW = $clog2(PATTERN_LEN+1);
    localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);
    localparam logic [FW-1:0] LAST = FW'(PATTERN_LEN-1);

    // The oldest history bit is shifted out before it is ever compared, so only
    // the newest PATTERN_LEN-1 bits need storing.
    logic [PATTERN_LEN-2:0] shreg;
    logic [PATTERN_LEN-1:0] cand;
    logic                   hit;

    always_comb begin
        cand = {shreg, X};
        hit  = en && (fill >= LAST) && (cand == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg <= '0;
            fill  <= '0;
            Y     <= 1'b0;
        end else begin
            Y <= hit;
            if (en) begin
                shreg <= cand[PATTERN_LEN-2:0];
                // Non-overlap restarts the fill count but keeps history bits.
                if (hit && !overlap)
                    fill <= '0;
                else if (fill != FULL)
                    fill <= fill + 1'b1;
            end
        end
    end

`ifdef SEQDET_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (count_clr)
            count <= COUNT_W'(hit);
        else if (hit && (count != '1))
            count <= count + 1'b1;
    end
`endif

endmodule
